// File: rtl/sr_pulse_ctrl.sv
// Conditions two raw asynchronous request lines into clean, mutually exclusive
// set/reset pulses for a downstream SR latch; colliding requests are flagged, not forwarded.
module sr_pulse_ctrl #(
    parameter int CNT_W    = 16,
    parameter int DEBOUNCE = 1000,
    parameter int PULSE_W  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic set_in,
    input  logic reset_in,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict
);

    localparam int                PC_W    = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
    localparam logic [CNT_W-1:0]  DB_MAX  = CNT_W'(DEBOUNCE - 1);
    localparam logic [PC_W-1:0]   PC_LOAD = PC_W'(PULSE_W - 1);

    typedef enum logic [1:0] {IDLE, DRIVE_S, DRIVE_R, GUARD} state_t;

    logic             set_p0, set_p1, clr_p0, clr_p1;
    logic             set_stable, clr_stable, set_stable_d, clr_stable_d;
    logic [CNT_W-1:0] set_cnt, clr_cnt;
    logic             req_s, req_r, eff_s, eff_r;
    logic             pend_s, pend_r, pend_s_nx, pend_r_nx;
    logic [PC_W-1:0]  pcnt, pcnt_nx;
    logic             conflict_nx;
    state_t           state, state_nx;

    // Stage p0/p1: two-flop synchronizers, then per-channel debounce counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_p0       <= 1'b0;
            set_p1       <= 1'b0;
            clr_p0       <= 1'b0;
            clr_p1       <= 1'b0;
            set_stable   <= 1'b0;
            clr_stable   <= 1'b0;
            set_stable_d <= 1'b0;
            clr_stable_d <= 1'b0;
            set_cnt      <= '0;
            clr_cnt      <= '0;
        end else begin
            set_p0       <= set_in;
            set_p1       <= set_p0;
            clr_p0       <= reset_in;
            clr_p1       <= clr_p0;
            set_stable_d <= set_stable;
            clr_stable_d <= clr_stable;

            if (set_p1 == set_stable) begin
                set_cnt <= '0;
            end else if (set_cnt == DB_MAX) begin
                set_stable <= set_p1;
                set_cnt    <= '0;
            end else begin
                set_cnt <= set_cnt + 1'b1;
            end

            if (clr_p1 == clr_stable) begin
                clr_cnt <= '0;
            end else if (clr_cnt == DB_MAX) begin
                clr_stable <= clr_p1;
                clr_cnt    <= '0;
            end else begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // Only a rising stable value is a request; falling edges are silent
    assign req_s = set_stable & ~set_stable_d;
    assign req_r = clr_stable & ~clr_stable_d;

    always_comb begin
        state_nx    = state;
        pcnt_nx     = pcnt;
        pend_s_nx   = pend_s;
        pend_r_nx   = pend_r;
        conflict_nx = 1'b0;
        eff_s       = req_s | pend_s;
        eff_r       = req_r | pend_r;
        case (state)
            IDLE: begin
                if (eff_s && eff_r) begin
                    conflict_nx = 1'b1;
                    pend_s_nx   = 1'b0;
                    pend_r_nx   = 1'b0;
                end else if (eff_s) begin
                    state_nx  = DRIVE_S;
                    pcnt_nx   = PC_LOAD;
                    pend_s_nx = 1'b0;
                end else if (eff_r) begin
                    state_nx  = DRIVE_R;
                    pcnt_nx   = PC_LOAD;
                    pend_r_nx = 1'b0;
                end
            end
            DRIVE_S, DRIVE_R: begin
                pend_s_nx = pend_s | req_s;
                pend_r_nx = pend_r | req_r;
                if (pcnt == '0) state_nx = GUARD;
                else            pcnt_nx  = pcnt - 1'b1;
            end
            GUARD: begin
                pend_s_nx = pend_s | req_s;
                pend_r_nx = pend_r | req_r;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stage p2: outputs registered from next state so s and r can never overlap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pcnt     <= '0;
            pend_s   <= 1'b0;
            pend_r   <= 1'b0;
            s        <= 1'b0;
            r        <= 1'b0;
            busy     <= 1'b0;
            conflict <= 1'b0;
        end else begin
            state    <= state_nx;
            pcnt     <= pcnt_nx;
            pend_s   <= pend_s_nx;
            pend_r   <= pend_r_nx;
            s        <= (state_nx == DRIVE_S);
            r        <= (state_nx == DRIVE_R);
            busy     <= (state_nx != IDLE);
            conflict <= conflict_nx;
        end
    end

endmodule

// File: tb/tb_sr_pulse_ctrl.sv
// Scoreboard bench for sr_pulse_ctrl with DEBOUNCE=4, PULSE_W=2: per-edge expected
// {s,r,busy,conflict} vectors are queued from the timing rules and compared after each edge.
module tb_sr_pulse_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic set_in = 1'b0;
    logic reset_in = 1'b0;
    logic s, r, busy, conflict;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_v;
    logic [3:0] got_v;

    sr_pulse_ctrl #(.CNT_W(16), .DEBOUNCE(4), .PULSE_W(2)) dut (
        .clk(clk), .rst(rst), .set_in(set_in), .reset_in(reset_in),
        .s(s), .r(r), .busy(busy), .conflict(conflict)
    );

    always #5 clk = ~clk;

    // Queue n per-edge expectations; edge numbers are 1-based, empty range when lo > hi
    task automatic push_exp(input int n, input int s0, input int s1, input int r0, input int r1,
                            input int b0, input int b1, input int b2, input int b3, input int c);
        for (int e = 1; e <= n; e++) begin
            exp_q.push_back({(e >= s0 && e <= s1), (e >= r0 && e <= r1),
                             ((e >= b0 && e <= b1) || (e >= b2 && e <= b3)), (e == c)});
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_in = 1'b1;
        push_exp(5, 1, 0, 1, 0, 1, 0, 1, 0, 0);
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            @(posedge clk); #1;
            exp_v = exp_q.pop_front(); got_v = {s, r, busy, conflict}; checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL reset_hold edge %0d: got srbc=%b expected %b", e, got_v, exp_v);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        push_exp(14, 7, 8, 1, 0, 7, 9, 1, 0, 0);
        for (int e = 1; e <= 14; e++) begin
            if (e > 1) @(negedge clk);
            @(posedge clk); #1;
            exp_v = exp_q.pop_front(); got_v = {s, r, busy, conflict}; checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL reset_release edge %0d: got srbc=%b expected %b", e, got_v, exp_v);
            end
        end
        push_exp(12, 1, 0, 1, 0, 1, 0, 1, 0, 0);
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            set_in = 1'b0;
            @(posedge clk); #1;
            exp_v = exp_q.pop_front(); got_v = {s, r, busy, conflict}; checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL reset_settle edge %0d: got srbc=%b expected %b", e, got_v, exp_v);
            end
        end
    endtask

    task automatic test_clean_set();
        push_exp(14, 7, 8, 1, 0, 7, 9, 1, 0, 0);
        push_exp(12, 1, 0, 1, 0, 1, 0, 1, 0, 0);
        for (int e = 1; e <= 26; e++) begin
            @(negedge clk);
            set_in = (e <= 14);
            @(posedge clk); #1;
            exp_v = exp_q.pop_front(); got_v = {s, r, busy, conflict}; checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL clean_set edge %0d: got srbc=%b expected %b", e, got_v, exp_v);
            end
        end
    endtask

    task automatic test_bounce();
        // final rising change drives edge 19, so the pulse lands on edges 25-26
        push_exp(32, 25, 26, 1, 0, 25, 27, 1, 0, 0);
        push_exp(12, 1, 0, 1, 0, 1, 0, 1, 0, 0);
        for (int e = 1; e <= 44; e++) begin
            @(negedge clk);
            if (e <= 20)      set_in = (((e - 1) / 3) % 2 == 0);
            else if (e <= 32) set_in = 1'b1;
            else              set_in = 1'b0;
            @(posedge clk); #1;
            exp_v = exp_q.pop_front(); got_v = {s, r, busy, conflict}; checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL bounce edge %0d: got srbc=%b expected %b", e, got_v, exp_v);
            end
        end
    endtask

    task automatic test_collision();
        push_exp(14, 1, 0, 1, 0, 1, 0, 1, 0, 7);
        push_exp(12, 1, 0, 1, 0, 1, 0, 1, 0, 0);
        for (int e = 1; e <= 26; e++) begin
            @(negedge clk);
            set_in   = (e <= 14);
            reset_in = (e <= 14);
            @(posedge clk); #1;
            exp_v = exp_q.pop_front(); got_v = {s, r, busy, conflict}; checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL collision edge %0d: got srbc=%b expected %b", e, got_v, exp_v);
            end
        end
    endtask

    task automatic test_pending();
        push_exp(16, 7, 8, 11, 12, 7, 9, 11, 13, 0);
        push_exp(12, 1, 0, 1, 0, 1, 0, 1, 0, 0);
        for (int e = 1; e <= 28; e++) begin
            @(negedge clk);
            set_in   = (e <= 16);
            reset_in = (e >= 2 && e <= 16);
            @(posedge clk); #1;
            exp_v = exp_q.pop_front(); got_v = {s, r, busy, conflict}; checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL pending edge %0d: got srbc=%b expected %b", e, got_v, exp_v);
            end
            checks++;
            if ((s & r) !== 1'b0) begin
                errors++;
                $display("FAIL pending_excl edge %0d: got s&r=%b expected 0", e, s & r);
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        push_exp(7, 7, 7, 1, 0, 7, 7, 1, 0, 0);
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            set_in = 1'b1;
            @(posedge clk); #1;
            exp_v = exp_q.pop_front(); got_v = {s, r, busy, conflict}; checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL mid_pulse_pre edge %0d: got srbc=%b expected %b", e, got_v, exp_v);
            end
        end
        #1;
        rst = 1'b0;
        set_in = 1'b0;
        #1;
        checks++;
        if ({s, r, busy, conflict} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_pulse_async: got srbc=%b expected 0000", {s, r, busy, conflict});
        end
        @(negedge clk);
        rst = 1'b1;
        push_exp(14, 1, 0, 1, 0, 1, 0, 1, 0, 0);
        for (int e = 1; e <= 14; e++) begin
            if (e > 1) @(negedge clk);
            @(posedge clk); #1;
            exp_v = exp_q.pop_front(); got_v = {s, r, busy, conflict}; checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL mid_pulse_post edge %0d: got srbc=%b expected %b", e, got_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_set();
        test_bounce();
        test_collision();
        test_pending();
        test_reset_mid_pulse();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_pulse_ctrl.md
# sr_pulse_ctrl

Input-conditioning stage that sits directly upstream of the SR latch and drives its `s`/`r` inputs. Two raw, asynchronous request lines (e.g. push-buttons) are synchronized and debounced. Each debounced rising edge becomes a clean, fixed-width `s` or `r` pulse. The block guarantees the latch never sees `s=r=1`: simultaneous requests are rejected and flagged instead of forwarded.

## Interface
- `CNT_W`, 16: width of each debounce counter; must satisfy `DEBOUNCE <= 2^CNT_W`.
- `DEBOUNCE`, 1000: consecutive cycles a synchronized input must differ from its stable value before the stable value flips; minimum 1.
- `PULSE_W`, 2: width of each `s`/`r` output pulse in clock cycles; minimum 1.

- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `set_in` in 1: raw set request, asynchronous to `clk`, may bounce.
- `reset_in` in 1: raw reset request, asynchronous to `clk`, may bounce.
- `s` out 1: set pulse to the latch, registered.
- `r` out 1: reset pulse to the latch, registered.
- `busy` out 1: high while a pulse or guard cycle is in progress (states DRIVE_S, DRIVE_R, GUARD).
- `conflict` out 1: one-cycle registered pulse when set and reset requests collide.

## Operation
- **Reset (`rst=0`):**
  - Immediately clears the synchronizers, stable values, counters, pending flags and pulse counter, and forces state to IDLE.
  - All outputs go to 0: `s=0`, `r=0`, `busy=0`, `conflict=0`.
- **Synchronizer:** two flops per input, reset to 0.
- **Debounce, per channel:**
  - `stable` resets to 0.
  - Each edge where the synchronized value equals `stable`: the counter is set to 0.
  - Each edge where they differ: if the counter equals `DEBOUNCE-1`, `stable` takes the synchronized value and the counter is set to 0; otherwise the counter increments.
- **Request:** `req = stable & ~stable_d`, a one-cycle pulse per channel. A falling `stable` only updates state and produces nothing.
- **Pending flags:** one per channel, one deep. A req arriving in a non-IDLE state sets its flag; a further req while the flag is set is absorbed.
- **FSM states:** IDLE, DRIVE_S, DRIVE_R, GUARD.
  - **IDLE:** compute the effective set request as (`req` or pending) for set, and likewise for reset.
    - Both effective: `conflict=1` for one cycle, both pending flags cleared, stay in IDLE.
    - Set only: go to DRIVE_S, load the pulse counter with `PULSE_W-1`, clear the set pending flag.
    - Reset only: go to DRIVE_R, symmetric to set.
  - **DRIVE_S / DRIVE_R:** `s=1` (respectively `r=1`) in every cycle of the state.
    - Counter at 0: go to GUARD.
    - Otherwise: decrement the counter.
  - **GUARD:** one cycle with `s=r=0`, then go to IDLE. Pending requests are served from IDLE.
- **Invariant:** `s & r == 0` in every cycle, including across reset.

## Timing
- The input changes before sampling edge 1.
- The synchronized value is valid after edge 2.
- `stable` flips at edge `DEBOUNCE+2`.
- `s`/`r` rise at edge `DEBOUNCE+3` and stay high for exactly `PULSE_W` cycles.
- Back-to-back service:
  - The minimum spacing between the rising edges of consecutive pulses is `PULSE_W+2` cycles (pulse + GUARD + IDLE decision).
  - A pending request is issued at edge P+`PULSE_W`+2, where P is the edge at which the previous pulse rose.
- Bounce shorter than `DEBOUNCE` cycles never flips `stable`.
- A glitch of any length that returns before `DEBOUNCE` consecutive differing samples produces no pulse.
- **Simultaneous events:**
  - Set and reset reqs in the same IDLE cycle, or one req plus the opposite pending flag: `conflict` rises one edge later and neither `s` nor `r` is driven.
  - A req coinciding with the last DRIVE cycle is pended, not dropped.
- **Reset mid-pulse:** `s`/`r` drop to 0 asynchronously, with no GUARD cycle. If an input is held high through reset release, it is re-debounced from `stable=0` and produces a new pulse at edge `DEBOUNCE+3` after release.
- **Counter width:** the comparison is against `DEBOUNCE-1`. The counter never wraps because it is cleared on reaching that value.

## Test plan
All scenarios use `DEBOUNCE=4`, `PULSE_W=2`.
- **Reset values:** hold `rst=0` with `set_in=1` -> `s=r=busy=conflict=0` throughout. Release `rst` -> `s=1` at edge 7 after release for 2 cycles, then `busy=0` 3 edges after the pulse starts.
- **Clean set:** `set_in` 0->1 held -> `s=1` on edges 7–8, `r=0` always, `busy=1` edges 7–9. Returning `set_in` to 0 produces no pulse.
- **Bounce:** `set_in` toggles with 3-cycle highs and lows for 20 cycles, then holds 1 -> exactly one `s` pulse, at edge 7 after the final rising change.
- **Collision:** `set_in` and `reset_in` rise on the same cycle -> `conflict=1` for one cycle at edge 7; `s` and `r` stay 0.
- **Pending:** `set_in` rises; `reset_in` rises 1 cycle later -> `s` on edges 7–8, GUARD at edge 9, `r` on edges 11–12; `s&r` never 1.
- **Reset mid-pulse:** assert `rst=0` during the first `s` cycle -> `s` falls within the same cycle; after release with inputs low, no further output.
